// File: rtl/mem_lsu_port.sv
// Load/store initiator for the simulation word memory.
// Turns byte-addressed load/store requests into word-addressed memory
// accesses with byte enables and lane-replicated write data. It returns one
// in-order response per request through a two-entry response FIFO. FLOP_OUT
// selects whether read data arrives in the accept cycle (0) or one cycle
// later (1). In the FLOP_OUT=1 case a single stage S1 carries the request
// context forward to meet that read data.
module mem_lsu_port #(
    parameter int AWIDTH   = 10,
    parameter bit FLOP_OUT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    // request channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH+1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    // memory port pair
    output logic              mem_wren,
    output logic [AWIDTH-1:0] mem_wraddr,
    output logic [31:0]       mem_wrdata,
    output logic [3:0]        mem_wrben,
    output logic [AWIDTH-1:0] mem_rdaddr,
    input  logic [31:0]       mem_rddata
);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    // Everything needed to shape the response once read data is available.
    typedef struct packed {
        logic [1:0] offset;
        size_e      size;
        logic       sgn;
        logic       we;
        logic       err;
    } ctx_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic       acc;
    logic       req_err;
    ctx_t       req_ctx;
    logic       s1_valid;
    logic       push;
    rsp_t       push_data;
    logic       pop;
    logic [1:0] outstanding;
    logic [1:0] outstanding_after_pop;

    rsp_t       fifo_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;

    // Shape one response from a request context and the raw memory word.
    function automatic rsp_t build_rsp(input ctx_t c, input logic [31:0] rd);
        rsp_t        r;
        logic [31:0] lane;
        lane    = rd >> {c.offset, 3'b000};
        r.err   = c.err;
        r.rdata = '0;
        if (!c.err && !c.we) begin
            unique case (c.size)
                SZ_BYTE: r.rdata = c.sgn ? {{24{lane[7]}}, lane[7:0]}
                                         : {24'h0, lane[7:0]};
                SZ_HALF: r.rdata = c.sgn ? {{16{lane[15]}}, lane[15:0]}
                                         : {16'h0, lane[15:0]};
                default: r.rdata = lane;
            endcase
        end
        return r;
    endfunction

    // Misalignment / illegal-size detection on the incoming request.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
        req_err = 1'b0;
        unique case (size_e'(req_size))
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = req_addr[0];
            SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end

    assign req_ctx.offset = req_addr[1:0];
    assign req_ctx.size   = size_e'(req_size);
    assign req_ctx.sgn    = req_signed;
    assign req_ctx.we     = req_we;
    assign req_ctx.err    = req_err;

    assign acc        = req_valid && req_ready;
    assign mem_wraddr = req_addr[AWIDTH+1:2];
    assign mem_rdaddr = req_addr[AWIDTH+1:2];
    assign mem_wren   = acc && req_we && !req_err;

    // Byte enables and lane-replicated write data; all zero when not writing.
    always_comb begin
        mem_wrben  = '0;
        mem_wrdata = '0;
        if (mem_wren) begin
            unique case (size_e'(req_size))
                SZ_BYTE: begin
                    mem_wrben  = 4'b0001 << req_addr[1:0];
                    mem_wrdata = {4{req_wdata[7:0]}};
                end
                SZ_HALF: begin
                    mem_wrben  = 4'b0011 << req_addr[1:0];
                    mem_wrdata = {2{req_wdata[15:0]}};
                end
                SZ_WORD: begin
                    mem_wrben  = 4'hF;
                    mem_wrdata = req_wdata;
                end
                default: begin
                    mem_wrben  = '0;
                    mem_wrdata = '0;
                end
            endcase
        end
    end

    generate
        if (FLOP_OUT) begin : g_flop
            logic s1_valid_q;
            ctx_t s1_ctx_q;

            // S1 carries the accepted request context to meet registered read data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
                    s1_valid_q <= 1'b0;
                    s1_ctx_q   <= '0;
                end else begin
                    s1_valid_q <= acc;
                    if (acc) begin
                        s1_ctx_q <= req_ctx;
                    end
                end
            end

            assign s1_valid  = s1_valid_q;
            assign push      = s1_valid_q;
            assign push_data = build_rsp(s1_ctx_q, mem_rddata);
        end else begin : g_comb
            assign s1_valid  = 1'b0;
            assign push      = acc;
            assign push_data = build_rsp(req_ctx, mem_rddata);
        end
    endgenerate

    // Flow control: never let more than two responses be owed downstream.
    assign rsp_valid             = (count_q != 2'd0);
    assign pop                   = rsp_valid && rsp_ready;
    assign outstanding           = {1'b0, s1_valid} + count_q;
    assign outstanding_after_pop = outstanding - {1'b0, pop};
    assign req_ready             = rst_n && (outstanding_after_pop < 2'd2);

    // Next FIFO occupancy from the push/pop pair.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // FIFO storage. A push at count 2 with a pop overwrites the slot being popped.
    always_ff @(posedge clk) begin
        // NOTE: storage is left unreset; outputs are gated by rsp_valid so stale entries never escape.
        if (push) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end

    assign rsp_rdata = rsp_valid ? fifo_q[rd_ptr_q].rdata : 32'h0;
    assign rsp_err   = rsp_valid ? fifo_q[rd_ptr_q].err   : 1'b0;

endmodule

// File: tb/tb_mem_lsu_port.sv
// Scoreboard bench for mem_lsu_port against a registered-read word memory.
module tb_mem_lsu_port;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW+1:0] req_addr;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          mem_wren;
    logic [AW-1:0] mem_wraddr;
    logic [31:0]   mem_wrdata;
    logic [3:0]    mem_wrben;
    logic [AW-1:0] mem_rdaddr;
    logic [31:0]   mem_rddata;

    always #5 clk = ~clk;

    mem_lsu_port #(.AWIDTH(AW), .FLOP_OUT(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_wren   (mem_wren),
        .mem_wraddr (mem_wraddr),
        .mem_wrdata (mem_wrdata),
        .mem_wrben  (mem_wrben),
        .mem_rdaddr (mem_rdaddr),
        .mem_rddata (mem_rddata)
    );

    // Word memory with byte enables and a registered read port.
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] rd_q;
    always @(posedge clk) begin
        if (mem_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wrben[b]) mem[mem_wraddr][8*b +: 8] <= mem_wrdata[8*b +: 8];
            end
        end
        rd_q <= mem[mem_rdaddr];
    end
    assign mem_rddata = rd_q;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int w;
    int total_waits;
    bit lat_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare whenever the DUT hands over a response.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rdata %h err %b with nothing expected", rsp_rdata, rsp_err);
            end else begin
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                if (lat_chk) check("rsp_latency", cyc, e.acc_cyc + 2);
            end
        end
    end

    // Present one request, wait (bounded) for acceptance, check memory-side outputs.
    task automatic issue(input logic we, input logic [11:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata, input logic [3:0] x_ben,
                         input logic [31:0] x_wdata, input logic [31:0] x_rdata,
                         input logic x_err, output int waits);
        exp_t e;
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        waits      = 0;
        @(negedge clk);
        while (!req_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready stayed 0 for addr %h", addr);
        end else begin
            check("mem_wren", {31'h0, mem_wren}, {31'h0, (x_ben != 4'h0)});
            check("mem_wrben", {28'h0, mem_wrben}, {28'h0, x_ben});
            check("mem_wrdata", mem_wrdata, x_wdata);
            check("mem_rdaddr", {22'h0, mem_rdaddr}, {22'h0, addr[11:2]});
            if (x_ben != 4'h0) check("mem_wraddr", {22'h0, mem_wraddr}, {22'h0, addr[11:2]});
            e.rdata   = x_rdata;
            e.err     = x_err;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wdata = 32'h0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses never arrived", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        for (int i = 0; i < 8; i++) mem[32 + i] = 32'h1000_0000 + i;
        rst_n      = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 12'h000;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_wdata  = 32'h1111_1111;
        rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state, with a store presented to prove nothing is written.
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        check("rst_mem_wren", {31'h0, mem_wren}, 32'h0);
        idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mem0_untouched", mem[0], 32'h0);

        // Stores and loads back to back, exact latency checked on each response.
        lat_chk = 1'b1;
        //    we    addr     sz    sg    wdata          ben    wrdata         rdata          err
        issue(1'b1, 12'h010, 2'd2, 1'b0, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h00000000, 1'b0, w);
        issue(1'b0, 12'h010, 2'd2, 1'b0, 32'h0,        4'h0, 32'h0,        32'hDEADBEEF, 1'b0, w);
        issue(1'b1, 12'h013, 2'd0, 1'b0, 32'h123456A5, 4'h8, 32'hA5A5A5A5, 32'h00000000, 1'b0, w);
        issue(1'b0, 12'h013, 2'd0, 1'b1, 32'h0,        4'h0, 32'h0,        32'hFFFFFFA5, 1'b0, w);
        issue(1'b0, 12'h013, 2'd0, 1'b0, 32'h0,        4'h0, 32'h0,        32'h000000A5, 1'b0, w);
        issue(1'b1, 12'h012, 2'd1, 1'b0, 32'hFFFF1234, 4'hC, 32'h12341234, 32'h00000000, 1'b0, w);
        issue(1'b0, 12'h010, 2'd1, 1'b1, 32'h0,        4'h0, 32'h0,        32'hFFFFBEEF, 1'b0, w);
        issue(1'b0, 12'h012, 2'd1, 1'b0, 32'h0,        4'h0, 32'h0,        32'h00001234, 1'b0, w);
        issue(1'b0, 12'h011, 2'd0, 1'b1, 32'h0,        4'h0, 32'h0,        32'hFFFFFFBE, 1'b0, w);
        issue(1'b0, 12'h012, 2'd0, 1'b0, 32'h0,        4'h0, 32'h0,        32'h00000034, 1'b0, w);
        // Misaligned / illegal requests: error response, no write.
        issue(1'b0, 12'h011, 2'd1, 1'b0, 32'h0,        4'h0, 32'h0,        32'h00000000, 1'b1, w);
        issue(1'b0, 12'h012, 2'd2, 1'b0, 32'h0,        4'h0, 32'h0,        32'h00000000, 1'b1, w);
        issue(1'b0, 12'h010, 2'd3, 1'b0, 32'h0,        4'h0, 32'h0,        32'h00000000, 1'b1, w);
        issue(1'b1, 12'h011, 2'd1, 1'b0, 32'h55555555, 4'h0, 32'h0,        32'h00000000, 1'b1, w);
        issue(1'b1, 12'h014, 2'd3, 1'b0, 32'h77777777, 4'h0, 32'h0,        32'h00000000, 1'b1, w);
        issue(1'b0, 12'h014, 2'd2, 1'b0, 32'h0,        4'h0, 32'h0,        32'h00000000, 1'b0, w);
        issue(1'b0, 12'h010, 2'd2, 1'b0, 32'h0,        4'h0, 32'h0,        32'h1234BEEF, 1'b0, w);
        idle();
        drain();

        // Eight back-to-back loads: one per cycle, req_ready never drops.
        total_waits = 0;
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 12'h080 + 12'(4 * i), 2'd2, 1'b0, 32'h0, 4'h0, 32'h0,
                  32'h1000_0000 + 32'(i), 1'b0, w);
            total_waits += w;
        end
        idle();
        check("b2b_ready_waits", total_waits, 0);
        drain();

        // Backpressure: two accepted, then stall with stable head data.
        lat_chk   = 1'b0;
        rsp_ready = 1'b0;
        issue(1'b0, 12'h080, 2'd2, 1'b0, 32'h0, 4'h0, 32'h0, 32'h10000000, 1'b0, w);
        issue(1'b0, 12'h084, 2'd2, 1'b0, 32'h0, 4'h0, 32'h0, 32'h10000001, 1'b0, w);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 12'h088;
        req_size  = 2'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_req_ready_low", {31'h0, req_ready}, 32'h0);
            check("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("bp_hold_rdata", rsp_rdata, 32'h10000000);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_on_pop", {31'h0, req_ready}, 32'h1);
        begin
            exp_t e;
            e.rdata   = 32'h10000002;
            e.err     = 1'b0;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        idle();
        @(negedge clk);
        check("bp_next_head", rsp_rdata, 32'h10000001);
        check("bp_ready_full", {31'h0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain();

        // Reset with two responses pending.
        rsp_ready = 1'b0;
        issue(1'b1, 12'h020, 2'd2, 1'b0, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, w);
        issue(1'b0, 12'h020, 2'd2, 1'b0, 32'h0, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, w);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("async_rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("async_rst_rsp_rdata", rsp_rdata, 32'h0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        lat_chk   = 1'b1;
        issue(1'b0, 12'h020, 2'd2, 1'b0, 32'h0, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, w);
        issue(1'b0, 12'h010, 2'd2, 1'b0, 32'h0, 4'h0, 32'h0, 32'h1234BEEF, 1'b0, w);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
